// File: rtl/pla_pkg.sv
// Shared PLA constants: default plane geometry and the controller state codes.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package pla_pkg;

   localparam int PLA_ROWS = 3;
   localparam int PLA_COLS = 7;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;

endpackage

// File: rtl/pla_and_plane.sv
// Combinational AND plane: each row ANDs the inputs its personality selects.
// Latency: zero cycles, purely combinational.
// Backpressure: none.
module pla_and_plane
   import pla_pkg::*;
#(
   parameter int ROWS = PLA_ROWS,
   parameter int COLS = PLA_COLS
) (
   input  logic [1:ROWS][1:COLS] mem,
   input  logic [1:COLS]         a,
   output logic [1:ROWS]         b_nxt
);

   // A personality bit of 0 masks its column to 1, so an all-zero row yields 1.
   always_comb begin
      b_nxt = '0;
      for (int r = 1; r <= ROWS; r++) begin
         b_nxt[r] = &(~mem[r] | a);
      end
   end

endmodule

// File: rtl/pla_prog_array.sv
// Serially programmed PLA AND plane with registered outputs and readback.
// Latency: b is registered one cycle after a is sampled; rd_data is combinational.
// Backpressure: prog_ready is high only while loading; bits are taken on prog_valid & prog_ready.
module pla_prog_array
   import pla_pkg::*;
#(
   parameter int ROWS = PLA_ROWS,
   parameter int COLS = PLA_COLS
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        prog_start,
   input  logic                        prog_valid,
   input  logic                        prog_bit,
   output logic                        prog_ready,
   output logic                        prog_done,
   input  logic [1:COLS]               a,
   output logic [1:ROWS]               b,
   input  logic [$clog2(ROWS+1)-1:0]   rd_row,
   output logic [1:COLS]               rd_data
);

   localparam int RW = $clog2(ROWS + 1);
   localparam int CW = $clog2(COLS + 1);
   localparam logic [RW-1:0] ROW_FIRST = RW'(1);
   localparam logic [RW-1:0] ROW_LAST  = RW'(ROWS);
   localparam logic [CW-1:0] COL_FIRST = CW'(1);
   localparam logic [CW-1:0] COL_LAST  = CW'(COLS);

   logic [1:0]              state_q, state_d;
   logic [RW-1:0]           row_q, row_d;
   logic [CW-1:0]           col_q, col_d;
   logic [1:ROWS][1:COLS]   mem_q, mem_d;
   logic [1:ROWS]           b_q, b_d;
   logic                    done_q, done_d;
   logic [1:ROWS]           plane_b;
   logic                    accept;

   pla_and_plane #(
      .ROWS (ROWS),
      .COLS (COLS)
   ) u_and_plane (
      .mem   (mem_q),
      .a     (a),
      .b_nxt (plane_b)
   );

   assign accept     = (state_q == ST_LOAD) && prog_valid;
   assign prog_ready = (state_q == ST_LOAD);
   assign prog_done  = done_q;
   assign b          = b_q;

   // Next-state: prog_start restarts loading and wins over a bit arriving the same cycle.
   always_comb begin
      state_d = state_q;
      row_d   = row_q;
      col_d   = col_q;
      mem_d   = mem_q;
      b_d     = b_q;
      done_d  = 1'b0;

      // Output register: evaluates only once already in RUN, holds through LOAD, zero in IDLE.
      case (state_q)
         ST_RUN:  b_d = plane_b;
         ST_LOAD: b_d = b_q;
         default: b_d = '0;
      endcase

      if (prog_start) begin
         state_d = ST_LOAD;
         row_d   = ROW_FIRST;
         col_d   = COL_FIRST;
      end else if (accept) begin
         mem_d[row_q][col_q] = prog_bit;
         if ((row_q == ROW_LAST) && (col_q == COL_LAST)) begin
            state_d = ST_RUN;
            done_d  = 1'b1;
         end else if (col_q == COL_LAST) begin
            col_d = COL_FIRST;
            row_d = row_q + RW'(1);
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   // Readback of one personality row; row 0 and rows past ROWS read as zero.
   always_comb begin
      rd_data = '0;
      if ((rd_row != '0) && (rd_row <= ROW_LAST)) begin
         rd_data = mem_q[rd_row];
      end
   end

   // State register with synchronous reset that wipes the personality too.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         row_q   <= ROW_FIRST;
         col_q   <= COL_FIRST;
         mem_q   <= '0;
         b_q     <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         col_q   <= col_d;
         mem_q   <= mem_d;
         b_q     <= b_d;
         done_q  <= done_d;
      end
   end

endmodule

// File: tb/tb_pla_prog_array.sv
// Self-checking bench for pla_prog_array: loads personalities, checks b via a scoreboard.
// Latency: expects b one cycle after a, prog_done the cycle after the last bit.
// Backpressure: drives prog_valid with random gaps, checks prog_ready per bit.
module tb_pla_prog_array;

   logic         clk = 1'b0;
   logic         rst;
   logic         prog_start;
   logic         prog_valid;
   logic         prog_bit;
   logic         prog_ready;
   logic         prog_done;
   logic [1:7]   a_i;
   logic [1:3]   b;
   logic [1:0]   rd_row;
   logic [1:7]   rd_data;

   int           n_cmp = 0;
   int           n_err = 0;
   int           idx   = 0;
   logic [1:3][1:7] mdl_mem;
   logic [1:3]   exp_b_cur;
   logic [1:3]   sb_q[$];

   pla_prog_array #(.ROWS(3), .COLS(7)) dut (
      .clk        (clk),
      .rst        (rst),
      .prog_start (prog_start),
      .prog_valid (prog_valid),
      .prog_bit   (prog_bit),
      .prog_ready (prog_ready),
      .prog_done  (prog_done),
      .a          (a_i),
      .b          (b),
      .rd_row     (rd_row),
      .rd_data    (rd_data)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [1:3] model_b(input logic [1:7] av);
      logic [1:3] rb;
      for (int r = 1; r <= 3; r++) begin
         rb[r] = 1'b1;
         for (int c = 1; c <= 7; c++) begin
            if (mdl_mem[r][c] && !av[c]) rb[r] = 1'b0;
         end
      end
      return rb;
   endfunction

   task automatic rd_check();
      for (int r = 0; r <= 3; r++) begin
         rd_row = 2'(r);
         #1;
         chk($sformatf("rd_row%0d", r), rd_data, (r == 0) ? 7'b0 : mdl_mem[r]);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      mdl_mem   = '0;
      exp_b_cur = '0;
      idx       = 0;
   endtask

   task automatic start_pulse();
      prog_start = 1'b1;
      tick();
      prog_start = 1'b0;
      idx = 0;
      chk("ready_in_load", prog_ready, 1);
      chk("b_hold_start", b, exp_b_cur);
   endtask

   task automatic send_bit(input logic v, input int gap);
      for (int g = 0; g < gap; g++) begin
         prog_valid = 1'b0;
         tick();
         chk("b_hold_gap", b, exp_b_cur);
      end
      prog_valid = 1'b1;
      prog_bit   = v;
      chk("ready_bit", prog_ready, 1);
      tick();
      prog_valid = 1'b0;
      mdl_mem[idx / 7 + 1][idx % 7 + 1] = v;
      idx++;
      chk("b_hold_bit", b, exp_b_cur);
   endtask

   task automatic load_rows(input logic [1:3][1:7] rows, input int max_gap);
      for (int i = 0; i < 21; i++) begin
         send_bit(rows[i / 7 + 1][i % 7 + 1], int'($urandom_range(max_gap, 0)));
         if (i < 20) chk("done_early", prog_done, 0);
      end
      chk("done_pulse", prog_done, 1);
      chk("ready_after_last", prog_ready, 0);
   endtask

   task automatic apply_vec(input logic [1:7] v);
      logic [1:3] e;
      a_i = v;
      chk("b_early", b, exp_b_cur);
      sb_q.push_back(model_b(v));
      tick();
      chk("done_clr", prog_done, 0);
      if (sb_q.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk($sformatf("b_for_a_%b", v), b, e);
         exp_b_cur = e;
      end
   endtask

   initial begin
      logic [1:3][1:7] rows_a;
      logic [1:3][1:7] rows_ones;
      rows_a    = {7'b1100000, 7'b0011100, 7'b0000000};
      rows_ones = {7'b1111111, 7'b1111111, 7'b1111111};

      rst = 1'b1; prog_start = 1'b0; prog_valid = 1'b0; prog_bit = 1'b0;
      a_i = '0; rd_row = '0; mdl_mem = '0; exp_b_cur = '0;
      tick();
      do_reset();
      chk("rst_ready", prog_ready, 0);
      chk("rst_done", prog_done, 0);
      chk("rst_b", b, 0);
      rd_check();

      // prog_valid in IDLE is ignored
      prog_valid = 1'b1; prog_bit = 1'b1; a_i = 7'b1111111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("idle_ready", prog_ready, 0);
         chk("idle_b", b, 0);
      end
      prog_valid = 1'b0;
      rd_check();

      // Load with random gaps and run the plane
      start_pulse();
      load_rows(rows_a, 3);
      rd_check();
      apply_vec(7'b1100000);
      apply_vec(7'b1111111);
      apply_vec(7'b0011100);
      apply_vec(7'b0000000);
      apply_vec(7'b1100000);

      // Reload from RUN: b holds while loading, then reflects the new plane
      start_pulse();
      a_i = 7'b1111110;
      load_rows(rows_ones, 2);
      apply_vec(7'b1111110);
      apply_vec(7'b1111111);
      rd_check();

      // Reset mid-load wins over prog_start and a valid bit
      start_pulse();
      for (int i = 0; i < 10; i++) send_bit(rows_a[i / 7 + 1][i % 7 + 1], 0);
      rst = 1'b1; prog_start = 1'b1; prog_valid = 1'b1; prog_bit = 1'b1;
      tick();
      rst = 1'b0; prog_start = 1'b0; prog_valid = 1'b0;
      mdl_mem = '0; exp_b_cur = '0; idx = 0;
      chk("midrst_ready", prog_ready, 0);
      chk("midrst_b", b, 0);
      chk("midrst_done", prog_done, 0);
      rd_check();
      tick();
      chk("midrst_still_idle", prog_ready, 0);

      // prog_start together with a valid bit: bit dropped, counters restart
      start_pulse();
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      prog_start = 1'b1; prog_valid = 1'b1; prog_bit = 1'b1;
      tick();
      prog_start = 1'b0; prog_valid = 1'b0;
      idx = 0;
      chk("restart_ready", prog_ready, 1);
      rd_check();
      load_rows(rows_a, 1);
      rd_check();
      apply_vec(7'b1100000);
      apply_vec(7'b0011100);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pla_prog_array.md
PLA_PROG_ARRAY -- requirements
Module: pla_prog_array

Interface
REQ-001 SHALL have parameter ROWS, default 3, number of AND-plane rows (outputs).
REQ-002 SHALL have parameter COLS, default 7, number of AND-plane columns (inputs).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on posedge clk.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port prog_start  input  1  request to (re)load the personality.
REQ-006 SHALL have port prog_valid  input  1  personality bit on prog_bit is valid.
REQ-007 SHALL have port prog_bit  input  1  serial personality bit.
REQ-008 SHALL have port prog_ready  output  1  block accepts a personality bit this cycle.
REQ-009 SHALL have port prog_done  output  1  one-cycle pulse when the personality is complete.
REQ-010 SHALL have port a  input  [1:COLS]  array inputs.
REQ-011 SHALL have port b  output  [1:ROWS]  registered array outputs.
REQ-012 SHALL have port rd_row  input  [$clog2(ROWS+1)-1:0]  personality readback row index, 1..ROWS.
REQ-013 SHALL have port rd_data  output  [1:COLS]  combinational readback of mem[rd_row]; all zeros if rd_row is out of range.

Function
REQ-014 SHALL hold the personality as mem[1:ROWS] of [1:COLS] bits, where bit 1 means the column participates in the row AND and bit 0 means don't-care.
REQ-015 SHALL implement states IDLE, LOAD and RUN.
REQ-016 SHALL move to LOAD from any state when prog_start=1, clearing the row/column counters to row 1, column 1.
REQ-017 SHALL give prog_start priority over a simultaneous bit acceptance.
REQ-018 SHALL drive prog_ready=1 only in LOAD.
REQ-019 SHALL accept a bit only at an edge where prog_valid=1 and prog_ready=1; prog_valid outside LOAD SHALL be ignored.
REQ-020 SHALL take bits row 1 first, and within each row column 1 first.
REQ-021 SHALL write each accepted bit to mem[row][col] at its acceptance edge.
REQ-022 SHALL wrap col to 1 and increment row after col=COLS.
REQ-023 SHALL, on accepting bit ROWS*COLS (21 at defaults), enter RUN at that edge and assert prog_done for exactly the following cycle.
REQ-024 SHALL deassert prog_ready in the cycle after the last bit is accepted.
REQ-025 SHALL, at each edge while in RUN, register b[r] = AND of a[c] over all c with mem[r][c]=1.
REQ-026 SHALL produce b[r]=1 for a row whose personality is all zeros.
REQ-027 SHALL make b valid one cycle after a is sampled.
REQ-028 SHALL update b for the first time at the first edge at which the state is already RUN (the edge after the last bit).
REQ-029 SHALL hold b at its last value in LOAD; b SHALL be 0 in IDLE.
REQ-030 SHALL leave mem unchanged by a partial load that is interrupted by prog_start; only overwritten bits change.

Reset
REQ-031 SHALL, at an edge with rst=1, set state=IDLE, clear all mem bits to 0, clear the counters, and drive b=0, prog_ready=0 and prog_done=0.
REQ-032 SHALL give rst priority over prog_start and over bit acceptance, including mid-LOAD.

Structure
REQ-033 SHALL place the ROWS/COLS defaults and the state enumeration (IDLE, LOAD, RUN) in shared package pla_pkg.
REQ-034 SHALL implement the combinational plane evaluation (mem, a -> next b) in one sub-module, pla_and_plane, instantiated once.
REQ-035 SHALL keep the FSM, counters, mem and the b register in pla_prog_array.

Verification
REQ-036 SHALL load rows 1100000, 0011100, 0000000, then check: a=1100000 -> b=101; a=1111111 -> b=111; a=0011100 -> b=011; each b appears one cycle after a.
REQ-037 SHALL apply prog_valid with random gaps -> exactly 21 bits accepted, prog_done high for 1 cycle, and rd_row=2 -> rd_data=0011100.
REQ-038 SHALL assert rst after 10 accepted bits -> state IDLE, rd_data=0000000 for all rows, b=000, prog_ready=0.
REQ-039 SHALL pulse prog_start in RUN with b=101 -> b holds 101 throughout LOAD; after reload with rows 1111111, 1111111, 1111111 and a=1111110 -> b=000.
REQ-040 SHALL drive prog_valid=1 in IDLE for 5 cycles -> no mem change and prog_ready=0.
REQ-041 SHALL assert prog_start together with an accepted bit -> bit discarded and counters at row 1, column 1.
